pixel_acq_fsm: RTL and testbench
================================

# pixel_acq_fsm

Acquisition sequencer that sits directly upstream of the pixel de-accumulation stage. On `i_start` it scans the full PIXEL_N_ROWS × PIXEL_N_COLS speckle sensor array, column-outer and row-inner. For each pixel it drives the array row/column selects, waits a settle time, runs one ADC conversion handshake and writes the raw accumulated sample into the frame RAM. When the whole frame is written it pulses `o_rdy`, which the controller uses to start the de-accumulation pass.

## Interface
- PIXEL_N_ROWS, 24, array rows
- PIXEL_N_COLS, 24, array columns
- NB_ADC, 12, ADC sample width
- NB_ADDR, 10, RAM address width; must be ≥ clog2(PIXEL_N_ROWS·PIXEL_N_COLS)
- SETTLE_CYCLES, 4, cycles spent in SETTLE after each select change; 0 skips SETTLE
- ADC_TIMEOUT, 255, maximum cycles in WAIT_ADC before ERROR
- clk  in  1  system clock; single clock domain, rising edge
- rst  in  1  asynchronous, active-low reset
- i_start  in  1  start a frame; sampled only in IDLE
- o_rdy  out  1  one-cycle pulse; frame fully written
- o_busy  out  1  high in every state except IDLE
- o_err  out  1  sticky ADC-timeout flag; cleared when the next `i_start` is accepted
- o_row_sel  out  5  array row select
- o_col_sel  out  5  array column select
- o_adc_start  out  1  one-cycle conversion request
- i_adc_done  in  1  conversion complete; `i_adc_data` valid in the same cycle
- i_adc_data  in  NB_ADC  conversion result
- o_ram_write  out  1  RAM write enable
- o_ram_addr  out  NB_ADDR  write address, = col·PIXEL_N_ROWS + row
- o_ram_value  out  NB_ADC  write data

## Operation
- States: IDLE, SELECT, SETTLE, CONVERT, WAIT_ADC, WRITE, ADVANCE, DONE, ERROR.
- IDLE → SELECT on `i_start`. On the same edge: row, col and addr are cleared to 0, and `o_err` is cleared.
- SELECT (1 cycle): `o_row_sel` and `o_col_sel` take the current row and col. Settle counter loads SETTLE_CYCLES. Next state is SETTLE, or CONVERT if SETTLE_CYCLES = 0.
- SETTLE: counter decrements. Exits to CONVERT after exactly SETTLE_CYCLES cycles.
- CONVERT (1 cycle): `o_adc_start` = 1. Timeout counter is cleared. Next state is WAIT_ADC.
- WAIT_ADC:
  - `i_adc_done` = 1: latch `i_adc_data`, go to WRITE.
  - Otherwise the timeout counter increments. On reaching ADC_TIMEOUT, go to ERROR.
  - `i_adc_done` is ignored in every other state, including the CONVERT cycle.
- WRITE (1 cycle): `o_ram_write` = 1, `o_ram_addr` = addr, `o_ram_value` = latched sample.
- ADVANCE (1 cycle):
  - row = PIXEL_N_ROWS−1 and col = PIXEL_N_COLS−1: go to DONE.
  - row = PIXEL_N_ROWS−1 otherwise: row wraps to 0 and col increments.
  - Otherwise row increments.
  - addr increments by 1 in every non-final case. Next state is SELECT.
- DONE (1 cycle): `o_rdy` = 1, then IDLE.
- ERROR (1 cycle): `o_err` is set, then IDLE. A partial frame stays in RAM and `o_rdy` is not pulsed.
- `i_start` outside IDLE is ignored. There is no queuing.
- Counters saturate-free by construction: row < PIXEL_N_ROWS, col < PIXEL_N_COLS, addr < PIXEL_N_ROWS·PIXEL_N_COLS at every write.

## Timing
- Reset (rst = 0, asynchronous, effective immediately): state = IDLE. All outputs are 0, including `o_err`, `o_row_sel` and `o_col_sel`. Reset mid-frame aborts without any further RAM write. Release is synchronous to the next rising edge.
- Per-pixel cycles = 1 + SETTLE_CYCLES + 1 + W + 1 + 1, where W = cycles spent in WAIT_ADC including the `i_adc_done` cycle (W ≥ 1).
- Frame timing: `i_start` sampled at edge e0 → first SELECT at e0+1 → DONE cycle begins at e0+1+N·(SETTLE_CYCLES+4+W), with N = PIXEL_N_ROWS·PIXEL_N_COLS.
- Error timing: ERROR is entered on the edge where the timeout counter reaches ADC_TIMEOUT, i.e. after ADC_TIMEOUT cycles in WAIT_ADC without done. `o_err` rises one cycle later and holds.
- All outputs are registered except `o_busy`, `o_rdy`, `o_adc_start` and `o_ram_write`, which are decoded from the state register.

## Structure
- Shared header `acq_defs.vh`: state encodings, default PIXEL_N_ROWS/COLS and NB_ADC (shared with the de-accumulation stage), and the address formula definition.
- One sub-module, `pixel_scan_counter`. It holds row, col and linear addr, with inputs clear and advance, and outputs row, col, addr and last.
- The FSM, settle counter, timeout counter and sample latch live in the top module.

## Test plan
- Full frame, default params, ADC model raises done 3 cycles after start (W = 3) → 576 writes; addr 0..575 in order; write k carries the model's sample for (col = k/24, row = k%24); `o_rdy` pulses once at e0+1+576·11.
- Row wrap check at pixel (row 23, col 0) → next SELECT shows row 0, col 1; next write addr = 24.
- ADC never responds, ADC_TIMEOUT = 255 → no write for that pixel; `o_err` = 1 after 255 WAIT_ADC cycles; FSM in IDLE; `o_rdy` never pulsed. A new `i_start` clears `o_err`.
- `i_adc_done` held high during the CONVERT cycle only → ignored; FSM remains in WAIT_ADC until a later done arrives.
- `i_start` pulsed while busy → ignored; exactly 576 writes and one `o_rdy`.
- rst = 0 asserted mid-WAIT_ADC of pixel 100 → all outputs 0 immediately; after release, idle until `i_start`; a new frame restarts at addr 0.

Source files
------------

// File: rtl/pixel_acq_fsm_pkg.sv
// Shared definitions for the pixel acquisition sequencer.
//   - default array geometry and ADC width, shared with the de-accumulation stage
//   - select-bus width driven to the sensor array
//   - sequencer state encoding
// RAM address convention used throughout: addr = col * PIXEL_N_ROWS + row.
package pixel_acq_fsm_pkg;

    localparam int PIXEL_N_ROWS_DEF = 24;
    localparam int PIXEL_N_COLS_DEF = 24;
    localparam int NB_ADC_DEF       = 12;

    // Width of the row/column select lines into the sensor array
    localparam int SEL_W = 5;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_SELECT   = 4'd1,
        ST_SETTLE   = 4'd2,
        ST_CONVERT  = 4'd3,
        ST_WAIT_ADC = 4'd4,
        ST_WRITE    = 4'd5,
        ST_ADVANCE  = 4'd6,
        ST_DONE     = 4'd7,
        ST_ERROR    = 4'd8
    } acq_state_e;

endpackage

// File: rtl/pixel_scan_counter.sv
// Column-outer / row-inner scan position for the acquisition sequencer.
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   clear         restart the scan at pixel (row 0, col 0), addr 0
//   advance       step to the next pixel; ignored on the final pixel
//   row, col      current pixel coordinates
//   addr          linear RAM address of the current pixel (col*N_ROWS + row)
//   last          current pixel is the final one of the frame
module pixel_scan_counter
    import pixel_acq_fsm_pkg::*;
#(
    parameter int N_ROWS  = PIXEL_N_ROWS_DEF,
    parameter int N_COLS  = PIXEL_N_COLS_DEF,
    parameter int NB_ADDR = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               advance,
    output logic [SEL_W-1:0]   row,
    output logic [SEL_W-1:0]   col,
    output logic [NB_ADDR-1:0] addr,
    output logic               last
);

    localparam logic [SEL_W-1:0] ROW_MAX = SEL_W'(N_ROWS - 1);
    localparam logic [SEL_W-1:0] COL_MAX = SEL_W'(N_COLS - 1);

    assign last = (row == ROW_MAX) && (col == COL_MAX);

    // The address is kept as a running count rather than recomputed from
    // row/col; column-outer ordering makes the two identical.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row  <= '0;
            col  <= '0;
            addr <= '0;
        end else if (clear) begin
            row  <= '0;
            col  <= '0;
            addr <= '0;
        end else if (advance && !last) begin
            if (row == ROW_MAX) begin
                row <= '0;
                col <= col + SEL_W'(1);
            end else begin
                row <= row + SEL_W'(1);
            end
            addr <= addr + NB_ADDR'(1);
        end
    end

endmodule

// File: rtl/pixel_acq_fsm.sv
// Acquisition sequencer: scans the sensor array column-outer / row-inner,
// settles, runs one ADC handshake per pixel and writes each raw sample into
// the frame RAM, then pulses o_rdy for the de-accumulation pass.
// Ports:
//   clk, rst              clock, asynchronous active-low reset
//   i_start               start a frame (only honoured in IDLE)
//   o_rdy                 one-cycle pulse: whole frame written
//   o_busy                high in every state except IDLE
//   o_err                 sticky ADC timeout flag, cleared by the next accepted start
//   o_row_sel, o_col_sel  array row/column selects
//   o_adc_start           one-cycle conversion request
//   i_adc_done, i_adc_data conversion complete strobe and its result
//   o_ram_write           RAM write enable
//   o_ram_addr            RAM write address (col*PIXEL_N_ROWS + row)
//   o_ram_value           RAM write data
module pixel_acq_fsm
    import pixel_acq_fsm_pkg::*;
#(
    parameter int PIXEL_N_ROWS  = PIXEL_N_ROWS_DEF,
    parameter int PIXEL_N_COLS  = PIXEL_N_COLS_DEF,
    parameter int NB_ADC        = NB_ADC_DEF,
    parameter int NB_ADDR       = 10,
    parameter int SETTLE_CYCLES = 4,
    parameter int ADC_TIMEOUT   = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_start,
    output logic               o_rdy,
    output logic               o_busy,
    output logic               o_err,
    output logic [SEL_W-1:0]   o_row_sel,
    output logic [SEL_W-1:0]   o_col_sel,
    output logic               o_adc_start,
    input  logic               i_adc_done,
    input  logic [NB_ADC-1:0]  i_adc_data,
    output logic               o_ram_write,
    output logic [NB_ADDR-1:0] o_ram_addr,
    output logic [NB_ADC-1:0]  o_ram_value
);

    localparam int SET_W = ($clog2(SETTLE_CYCLES + 1) > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam int TMO_W = ($clog2(ADC_TIMEOUT + 1) > 0) ? $clog2(ADC_TIMEOUT + 1) : 1;

    localparam logic [SET_W-1:0] SET_LOAD = SET_W'(SETTLE_CYCLES);
    localparam logic [SET_W-1:0] SET_ONE  = SET_W'(1);
    // Compared before the increment so ERROR is entered on the edge where
    // the count reaches ADC_TIMEOUT.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ADC_TIMEOUT - 1);

    acq_state_e state;
    acq_state_e state_next;

    logic [SET_W-1:0]   settle_cnt;
    logic [TMO_W-1:0]   tmo_cnt;
    logic [SEL_W-1:0]   scan_row;
    logic [SEL_W-1:0]   scan_col;
    logic [NB_ADDR-1:0] scan_addr;
    logic               scan_last;
    logic               start_acc;

    assign start_acc = (state == ST_IDLE) && i_start;

    pixel_scan_counter #(
        .N_ROWS  (PIXEL_N_ROWS),
        .N_COLS  (PIXEL_N_COLS),
        .NB_ADDR (NB_ADDR)
    ) u_scan (
        .clk     (clk),
        .rst     (rst),
        .clear   (start_acc),
        .advance (state == ST_ADVANCE),
        .row     (scan_row),
        .col     (scan_col),
        .addr    (scan_addr),
        .last    (scan_last)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE:     if (i_start) state_next = ST_SELECT;
            ST_SELECT:   state_next = (SETTLE_CYCLES == 0) ? ST_CONVERT : ST_SETTLE;
            ST_SETTLE:   if (settle_cnt == SET_ONE) state_next = ST_CONVERT;
            ST_CONVERT:  state_next = ST_WAIT_ADC;
            ST_WAIT_ADC: begin
                if (i_adc_done) begin
                    state_next = ST_WRITE;
                end else if (tmo_cnt == TMO_LAST) begin
                    state_next = ST_ERROR;
                end
            end
            ST_WRITE:    state_next = ST_ADVANCE;
            ST_ADVANCE:  state_next = scan_last ? ST_DONE : ST_SELECT;
            ST_DONE:     state_next = ST_IDLE;
            ST_ERROR:    state_next = ST_IDLE;
            default:     state_next = ST_IDLE;
        endcase
    end

    // Outputs decoded straight from the state register
    always_comb begin
        o_busy      = (state != ST_IDLE);
        o_rdy       = 1'b0;
        o_adc_start = 1'b0;
        o_ram_write = 1'b0;
        unique case (state)
            ST_CONVERT: o_adc_start = 1'b1;
            ST_WRITE:   o_ram_write = 1'b1;
            ST_DONE:    o_rdy       = 1'b1;
            default:    ;
        endcase
    end

    // Counters, sample latch and registered outputs. Everything is cleared
    // by reset so an aborted frame leaves the array and RAM ports quiet.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            settle_cnt  <= '0;
            tmo_cnt     <= '0;
            o_ram_value <= '0;
            o_ram_addr  <= '0;
            o_row_sel   <= '0;
            o_col_sel   <= '0;
            o_err       <= 1'b0;
        end else begin
            // The scan address only moves in ADVANCE, so the one-cycle lag
            // here has settled long before the next WRITE.
            o_ram_addr <= scan_addr;
            unique case (state)
                ST_IDLE: begin
                    if (i_start) o_err <= 1'b0;
                end
                ST_SELECT: begin
                    settle_cnt <= SET_LOAD;
                    o_row_sel  <= scan_row;
                    o_col_sel  <= scan_col;
                end
                ST_SETTLE: begin
                    settle_cnt <= settle_cnt - SET_ONE;
                end
                ST_CONVERT: begin
                    tmo_cnt <= '0;
                end
                ST_WAIT_ADC: begin
                    if (i_adc_done) begin
                        o_ram_value <= i_adc_data;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                ST_ERROR: begin
                    o_err <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_acq_fsm.sv
module tb_pixel_acq_fsm;

    localparam int R       = 24;
    localparam int C       = 24;
    localparam int NB_ADC  = 12;
    localparam int NB_ADDR = 10;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               i_start = 1'b0;
    logic               i_adc_done = 1'b0;
    logic [NB_ADC-1:0]  i_adc_data = '0;
    logic               o_rdy;
    logic               o_busy;
    logic               o_err;
    logic [4:0]         o_row_sel;
    logic [4:0]         o_col_sel;
    logic               o_adc_start;
    logic               o_ram_write;
    logic [NB_ADDR-1:0] o_ram_addr;
    logic [NB_ADC-1:0]  o_ram_value;

    pixel_acq_fsm #(
        .PIXEL_N_ROWS  (R),
        .PIXEL_N_COLS  (C),
        .NB_ADC        (NB_ADC),
        .NB_ADDR       (NB_ADDR),
        .SETTLE_CYCLES (4),
        .ADC_TIMEOUT   (255)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_start     (i_start),
        .o_rdy       (o_rdy),
        .o_busy      (o_busy),
        .o_err       (o_err),
        .o_row_sel   (o_row_sel),
        .o_col_sel   (o_col_sel),
        .o_adc_start (o_adc_start),
        .i_adc_done  (i_adc_done),
        .i_adc_data  (i_adc_data),
        .o_ram_write (o_ram_write),
        .o_ram_addr  (o_ram_addr),
        .o_ram_value (o_ram_value)
    );

    always #5 clk = ~clk;

    typedef struct {
        int delay;       // ADC done this many cycles after o_adc_start (W)
        int fail_at;     // ADC stops answering from this pixel on (-1: never)
        bit conv_done;   // also raise done during the CONVERT cycle
        bit glitch;      // pulse i_start mid-frame and during DONE
        int exp_writes;
        int exp_rdy;
        int exp_rdy_rel; // DONE cycle relative to the start-sampling cycle
        bit exp_err;
        int exp_busy;
    } vec_t;

    vec_t vecs[5];

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int adc_cnt, wr_cnt, rdy_cnt, rdy_cyc, busy_cnt, dly_cnt;
    bit err_busy;
    int cfg_delay, cfg_fail_at;
    bit cfg_conv_done;

    function automatic logic [NB_ADC-1:0] samp(input int k);
        return NB_ADC'((k * 7 + 'h155) & 'hFFF);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle: sample outputs on the falling edge, then drive the
    // ADC model's inputs for the remainder of the cycle.
    task automatic step();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (o_busy) busy_cnt++;
        if (o_busy && o_err) err_busy = 1'b1;
        if (o_rdy) begin
            rdy_cnt++;
            rdy_cyc = cyc;
        end
        if (o_adc_start)
            check("sel", {o_col_sel, o_row_sel}, {5'(adc_cnt / R), 5'(adc_cnt % R)});
        if (o_ram_write) begin
            check("wr_addr", o_ram_addr, wr_cnt);
            check("wr_data", o_ram_value, samp(wr_cnt));
            wr_cnt++;
        end
        i_adc_done = 1'b0;
        i_adc_data = 12'hABC;
        if (dly_cnt > 0) begin
            dly_cnt--;
            if (dly_cnt == 0) begin
                i_adc_done = 1'b1;
                i_adc_data = samp(int'(o_col_sel) * R + int'(o_row_sel));
            end
        end
        if (o_adc_start) begin
            if (cfg_conv_done) i_adc_done = 1'b1;
            if (cfg_fail_at < 0 || adc_cnt < cfg_fail_at) dly_cnt = cfg_delay;
            adc_cnt++;
        end
    endtask

    task automatic arm(input vec_t v);
        cfg_delay     = v.delay;
        cfg_fail_at   = v.fail_at;
        cfg_conv_done = v.conv_done;
        adc_cnt  = 0;
        wr_cnt   = 0;
        rdy_cnt  = 0;
        rdy_cyc  = -1;
        busy_cnt = 0;
        err_busy = 1'b0;
        dly_cnt  = 0;
    endtask

    task automatic run_frame(input vec_t v);
        int x;
        bit expired;
        arm(v);
        i_start = 1'b1;
        x = cyc;
        step();
        i_start = 1'b0;
        check("err_clr", o_err, 0);
        expired = 1'b1;
        for (int t = 0; t < 20000; t++) begin
            if (!o_busy) begin
                expired = 1'b0;
                break;
            end
            if (v.glitch && (cyc == x + 50 || cyc == x + v.exp_rdy_rel)) i_start = 1'b1;
            step();
            i_start = 1'b0;
        end
        check("frame_bound", expired, 0);
        check("writes", wr_cnt, v.exp_writes);
        check("rdy_cnt", rdy_cnt, v.exp_rdy);
        if (v.exp_rdy > 0) check("rdy_time", rdy_cyc - x, v.exp_rdy_rel);
        check("busy_cycles", busy_cnt, v.exp_busy);
        check("err_while_busy", err_busy, 0);
        check("err_final", o_err, v.exp_err);
        repeat (3) step();
        check("stay_idle", {o_busy, o_ram_write, o_adc_start, o_rdy}, 0);
        check("err_hold", o_err, v.exp_err);
    endtask

    initial begin
        vec_t v;
        bit expired;
        //          dly fail conv glt writes rdy rel   err busy
        vecs[0] = '{3, -1, 1'b0, 1'b0, 576, 1, 6337, 1'b0, 6337};
        vecs[1] = '{3,  3, 1'b0, 1'b0,   3, 0,    0, 1'b1,  295};
        vecs[2] = '{5, -1, 1'b1, 1'b0, 576, 1, 7489, 1'b0, 7489};
        vecs[3] = '{2, -1, 1'b0, 1'b1, 576, 1, 5761, 1'b0, 5761};
        vecs[4] = '{1, -1, 1'b0, 1'b0, 576, 1, 5185, 1'b0, 5185};
        arm(vecs[0]);

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_ctrl", {o_rdy, o_busy, o_err, o_adc_start, o_ram_write, o_row_sel, o_col_sel}, 0);
        check("rst_data", {o_ram_addr, o_ram_value}, 0);
        rst = 1'b1;
        repeat (3) step();
        check("idle_after_rst", {o_busy, o_err}, 0);

        for (int i = 0; i < 5; i++) run_frame(vecs[i]);

        // Reset asserted during WAIT_ADC of pixel 100
        v = vecs[0];
        arm(v);
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        expired = 1'b1;
        for (int t = 0; t < 3000; t++) begin
            if (adc_cnt == 101) begin
                expired = 1'b0;
                break;
            end
            step();
        end
        check("reach_pix100", expired, 0);
        step();
        check("busy_pre_rst", {o_busy, o_col_sel, o_row_sel}, {1'b1, 5'd4, 5'd4});
        dly_cnt = 0;
        i_adc_done = 1'b0;
        rst = 1'b0;
        #1;
        check("async_rst_ctrl", {o_rdy, o_busy, o_err, o_adc_start, o_ram_write, o_row_sel, o_col_sel}, 0);
        check("async_rst_data", {o_ram_addr, o_ram_value}, 0);
        repeat (3) step();
        rst = 1'b1;
        repeat (5) step();
        check("no_write_after_rst", wr_cnt, 100);
        check("idle_no_start", {o_busy, o_rdy, o_adc_start}, 0);
        run_frame(vecs[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
